rgb_pwm_driver: RTL and testbench

Three-channel PWM output stage for the continuous colour wheel. It sits downstream of the fade/colour sequencing logic. It accepts a duty-cycle triple over a valid/ready handshake and double-buffers it so that updates only take effect on PWM period boundaries, which keeps the output glitch-free. It drives three active-low LED pins.

---
 rtl/rgb_pwm_driver.sv | 86 ++++++++
 tb/tb_rgb_pwm_driver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: double-buffered three-channel active-low PWM stage.
// Define RGB_PWM_STAGGER_EN to offset the G and B phases by a third of a period each.
module rgb_pwm_driver #(
   parameter int PWM_INTERVAL = 1200,
   parameter int W = $clog2(PWM_INTERVAL)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] duty_r,
   input  logic [W-1:0] duty_g,
   input  logic [W-1:0] duty_b,
   input  logic         duty_valid,
   output logic         duty_ready,
   output logic         period_start,
   output logic         RED,
   output logic         GRN,
   output logic         BLU
);
   localparam logic [W:0] P = (W+1)'(PWM_INTERVAL);
   localparam logic [W-1:0] LAST = W'(PWM_INTERVAL - 1);
`ifdef RGB_PWM_STAGGER_EN
   localparam logic [W:0] OFF [3] = '{'0, (W+1)'(PWM_INTERVAL / 3), (W+1)'(2 * PWM_INTERVAL / 3)};
`else
   localparam logic [W:0] OFF [3] = '{'0, '0, '0};
`endif
   logic [W-1:0] cnt;
   logic [W-1:0] duty [3];
   logic [W-1:0] pend [3];
   logic [W-1:0] act [3];
   logic [W-1:0] ph [3];
   logic [W:0]   sum [3];
   logic [2:0]   ld, ld_next, load, on, pin;
   logic         pend_full;

   assign duty[0] = duty_r;
   assign duty[1] = duty_g;
   assign duty[2] = duty_b;
   assign duty_ready = ~pend_full & ~rst;
   assign RED = pin[0];
   assign GRN = pin[1];
   assign BLU = pin[2];

   // Each channel runs on its own phase and picks up pending duty on its own phase wrap.
   always_comb begin
      sum = '{default: '0};
      ph = '{default: '0};
      on = '0;
      load = '0;
      for (int i = 0; i < 3; i++) begin
         sum[i] = {1'b0, cnt} + P - OFF[i];
         ph[i] = sum[i] >= P ? W'(sum[i] - P) : W'(sum[i]);
         on[i] = ph[i] < act[i];
         load[i] = pend_full & ~ld[i] & (ph[i] == LAST);
      end
      ld_next = ld | load;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         pend_full <= 1'b0;
         ld <= '0;
         pin <= '1;
         period_start <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            act[i] <= '0;
            pend[i] <= '0;
         end
      end else begin
         cnt <= cnt == LAST ? '0 : cnt + 1'b1;
         period_start <= cnt == '0;
         pin <= ~on;
         ld <= &ld_next ? '0 : ld_next;
         if (&ld_next)
            pend_full <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            if (load[i])
               act[i] <= pend[i];
            if (duty_valid & duty_ready)
               pend[i] <= duty[i];
         end
         if (duty_valid & duty_ready)
            pend_full <= 1'b1;
      end
   end
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: scoreboard bench for rgb_pwm_driver with PWM_INTERVAL = 12.
// Define RGB_PWM_STAGGER_EN to run the staggered-phase scenario instead of the default ones.
module tb_rgb_pwm_driver;
   localparam int P = 12;
   localparam int W = $clog2(P);
`ifdef RGB_PWM_STAGGER_EN
   localparam int OG = P / 3;
   localparam int OB = 2 * P / 3;
`else
   localparam int OG = 0;
   localparam int OB = 0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [W-1:0] duty_r = '0, duty_g = '0, duty_b = '0;
   logic duty_valid = 1'b0;
   logic duty_ready, period_start, RED, GRN, BLU;
   int passed = 0;
   int total = 0;
   int st = 0;
   typedef struct { int k; int r; int g; int b; } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   rgb_pwm_driver #(.PWM_INTERVAL(P)) dut (
      .clk(clk), .rst(rst),
      .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
      .duty_valid(duty_valid), .duty_ready(duty_ready),
      .period_start(period_start),
      .RED(RED), .GRN(GRN), .BLU(BLU)
   );

   // Expected pin pattern over one period; bit pos is the pin value at period position pos.
   function automatic int pat(int d, int off);
      int v = 0;
      for (int pos = 0; pos < P; pos++)
         if (!(((pos + P - off) % P) < d))
            v = v | (1 << pos);
      return v;
   endfunction

   task automatic check(string name, int act, int req);
      total++;
      if (act == req)
         passed++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", name, act, req, st);
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         st++;
      end
   endtask

   task automatic goto(int t);
      step(t - st);
   endtask

   task automatic push_exp(int k, int r, int g, int b);
      exp_t e;
      e.k = k;
      e.r = r;
      e.g = g;
      e.b = b;
      q.push_back(e);
   endtask

   task automatic send(int r, int g, int b, int exp_ta);
      int n = 0;
      duty_r = W'(r);
      duty_g = W'(g);
      duty_b = W'(b);
      duty_valid = 1'b1;
      while (!duty_ready && n < 40) begin
         step(1);
         n++;
      end
      check("accept_cycle", st, exp_ta);
      step(1);
      duty_valid = 1'b0;
   endtask

   // Monitor: per-cycle reset/period_start checks, per-period pin patterns against the queue.
   initial begin
      int t = 0;
      int pos, k;
      int rp = 0, gp = 0, bp = 0;
      bit prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (prev) begin
            check("rst_pins", int'({RED, GRN, BLU}), 7);
            check("rst_period_start", int'(period_start), 0);
         end
         if (rst) begin
            check("rst_ready", int'(duty_ready), 0);
            t = 0;
         end else begin
            check("period_start", int'(period_start), int'((t % P) == 1));
            if (t > 0) begin
               pos = (t - 1) % P;
               rp = RED ? (rp | (1 << pos)) : (rp & ~(1 << pos));
               gp = GRN ? (gp | (1 << pos)) : (gp & ~(1 << pos));
               bp = BLU ? (bp | (1 << pos)) : (bp & ~(1 << pos));
               if (pos == P - 1) begin
                  k = (t - 1) / P;
                  while (q.size() > 0 && q[0].k < k) begin
                     check("missed_period", q[0].k, k);
                     void'(q.pop_front());
                  end
                  if (q.size() > 0 && q[0].k == k) begin
                     e = q.pop_front();
                     check("red_period", rp, pat(e.r, 0));
                     check("grn_period", gp, pat(e.g, OG));
                     check("blu_period", bp, pat(e.b, OB));
                  end
               end
            end
            t++;
         end
         prev = rst;
      end
   end

   initial begin
      duty_r = 4'd7;
      duty_g = 4'd7;
      duty_b = 4'd7;
      duty_valid = 1'b1;
      step(3);
      rst = 1'b0;
      duty_valid = 1'b0;
      st = 0;
      #1;
      check("ready_after_rst", int'(duty_ready), 1);
`ifdef RGB_PWM_STAGGER_EN
      push_exp(0, 0, 0, 0);
      push_exp(1, 4, 4, 4);
      goto(8);
      send(4, 4, 4, 8);
      check("stagger_ready_drop", int'(duty_ready), 0);
      goto(19);
      check("stagger_ready_before_blu", int'(duty_ready), 0);
      goto(20);
      check("stagger_ready_after_blu", int'(duty_ready), 1);
      goto(30);
`else
      push_exp(0, 0, 0, 0);
      push_exp(1, 3, 6, 12);
      goto(5);
      send(3, 6, 12, 5);
      check("ready_drop", int'(duty_ready), 0);
      goto(11);
      check("ready_before_wrap", int'(duty_ready), 0);
      goto(12);
      check("ready_after_wrap", int'(duty_ready), 1);
      push_exp(2, 15, 0, 11);
      goto(17);
      send(15, 0, 11, 17);
      push_exp(3, 1, 2, 3);
      push_exp(4, 4, 5, 6);
      goto(29);
      send(1, 2, 3, 29);
      check("backpressure_ready", int'(duty_ready), 0);
      send(4, 5, 6, 36);
      push_exp(5, 4, 5, 6);
      push_exp(6, 5, 9, 2);
      goto(59);
      send(5, 9, 2, 59);
      goto(87);
      send(8, 8, 8, 87);
      check("pending_full_ready", int'(duty_ready), 0);
      goto(89);
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      st = 0;
      #1;
      check("ready_after_mid_rst", int'(duty_ready), 1);
      push_exp(0, 0, 0, 0);
      push_exp(1, 0, 0, 0);
      goto(30);
`endif
      check("queue_empty", q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
